// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the MIPS data-cache miss controller.
// A word is four bytes with byte 0 in the most significant position.
package mips_cache_pkg;

  localparam int INDEX_W_DEF = 12;
  localparam int TAG_W_DEF   = 2;

  typedef logic [0:3][7:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_e;

  // Rebuilds the word-aligned memory address of a line from its tag and index.
  // Address bits above the tag are always zero in this memory map.
  function automatic logic [31:0] victim_addr(input logic [31:0] tag,
                                              input logic [31:0] index,
                                              input int          indexW);
    return (tag << (indexW + 2)) | (index << 2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate miss handler for a direct-mapped data cache:
// probes the cache, evicts dirty victims, refills from memory, then retires the access.
module cache_controller
  import mips_cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  word_t            cpu_wdata,
  output word_t            cpu_rdata,
  output logic             cpu_stall,
  output logic [31:0]      cache_addr,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  input  logic [TAG_W-1:0] cache_victim_tag,
  input  word_t            cache_rdata,
  output word_t            cache_wdata,
  output logic             cache_write_en,
  output logic             cache_mark_dirty,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output word_t            mem_wdata,
  input  word_t            mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  cache_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  word_t            wdata_q, wdata_d;
  logic             refilled_q, refilled_d;
  word_t            victimData_q, victimData_d;
  logic [TAG_W-1:0] victimTag_q, victimTag_d;
  logic             stallRaw, hitInc, missInc;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      refilled_q   <= 1'b0;
      victimData_q <= '0;
      victimTag_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      refilled_q   <= refilled_d;
      victimData_q <= victimData_d;
      victimTag_q  <= victimTag_d;
    end
  end

  // A hit on the access that just refilled the line is not counted as a hit.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    refilled_d       = refilled_q;
    victimData_d     = victimData_q;
    victimTag_d      = victimTag_q;
    stallRaw         = 1'b0;
    hitInc           = 1'b0;
    missInc          = 1'b0;
    cpu_rdata        = '0;
    cache_wdata      = '0;
    cache_write_en   = 1'b0;
    cache_mark_dirty = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state_q)
      IDLE: begin
        stallRaw = cpu_req;
        if (cpu_req) begin
          addr_d     = cpu_addr;
          we_d       = cpu_we;
          wdata_d    = cpu_wdata;
          refilled_d = 1'b0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (cache_hit) begin
          cpu_rdata = cache_rdata;
          hitInc    = !refilled_q;
          if (we_q) begin
            cache_write_en   = 1'b1;
            cache_wdata      = wdata_q;
            cache_mark_dirty = 1'b1;
          end
          state_d = IDLE;
        end else begin
          stallRaw     = 1'b1;
          missInc      = 1'b1;
          victimData_d = cache_rdata;
          victimTag_d  = cache_victim_tag;
          state_d      = cache_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        stallRaw  = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_addr(32'(victimTag_q), 32'(addr_q[INDEX_W+1:2]), INDEX_W);
        mem_wdata = victimData_q;
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        stallRaw = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (mem_ready) begin
          cache_write_en = 1'b1;
          cache_wdata    = mem_rdata;
          refilled_d     = 1'b1;
          state_d        = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset returns the FSM to IDLE, where stall would follow cpu_req; force it low instead.
  assign cpu_stall  = rst_b & stallRaw;
  assign cache_addr = addr_q;

  sat_counter u_hitCounter (
    .clk     (clk),
    .rst_b   (rst_b),
    .inc_i   (hitInc),
    .count_o (hit_count)
  );

  sat_counter u_missCounter (
    .clk     (clk),
    .rst_b   (rst_b),
    .inc_i   (missInc),
    .count_o (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural direct-mapped cache
// and a memory whose response delay is set per scenario.
module tb_cache_controller;
  import mips_cache_pkg::*;

  logic        clk, rst_b;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  word_t       cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic [31:0] cache_addr;
  logic        cache_hit, cache_dirty;
  logic [1:0]  cache_victim_tag;
  word_t       cache_rdata, cache_wdata;
  logic        cache_write_en, cache_mark_dirty;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr;
  word_t       mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;

  cache_controller #(.INDEX_W(12), .TAG_W(2)) dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
    .cache_victim_tag(cache_victim_tag), .cache_rdata(cache_rdata),
    .cache_wdata(cache_wdata), .cache_write_en(cache_write_en),
    .cache_mark_dirty(cache_mark_dirty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cache: index = addr[13:2], tag = addr[15:14]
  bit         cValid [4096];
  bit [1:0]   cTag   [4096];
  bit         cDirty [4096];
  word_t      cData  [4096];
  logic [11:0] cIdx;
  int         cacheWrCount = 0;
  word_t      lastCacheWdata;
  logic       lastCacheDirty;

  assign cIdx             = cache_addr[13:2];
  assign cache_hit        = cValid[cIdx] && (cTag[cIdx] == cache_addr[15:14]);
  assign cache_dirty      = cValid[cIdx] && cDirty[cIdx];
  assign cache_victim_tag = cTag[cIdx];
  assign cache_rdata      = cData[cIdx];

  always @(posedge clk) begin
    if (cache_write_en) begin
      cValid[cIdx]   <= 1'b1;
      cTag[cIdx]     <= cache_addr[15:14];
      cDirty[cIdx]   <= cache_mark_dirty;
      cData[cIdx]    <= cache_wdata;
      cacheWrCount   <= cacheWrCount + 1;
      lastCacheWdata <= cache_wdata;
      lastCacheDirty <= cache_mark_dirty;
    end
  end

  // Memory: ready in the memWait-th cycle of each request; completed transactions logged
  word_t       memArr [16384];
  int          memWait = 1;
  int          memCnt = 0;
  int          memReqCycles = 0;
  int          logCount = 0;
  logic [31:0] logAddr [64];
  logic        logWe   [64];
  word_t       logData [64];

  assign mem_rdata = memArr[mem_addr[15:2]];
  assign mem_ready = mem_req && ((memCnt + 1) >= memWait);

  always @(posedge clk) begin
    if (mem_req) begin
      memReqCycles <= memReqCycles + 1;
      if (mem_ready) begin
        logAddr[logCount] <= mem_addr;
        logWe[logCount]   <= mem_we;
        logData[logCount] <= mem_wdata;
        logCount          <= logCount + 1;
        memCnt            <= 0;
      end else begin
        memCnt <= memCnt + 1;
      end
    end else begin
      memCnt <= 0;
    end
  end

  // Protocol watch: request stability while waiting, and no cache write during a memory write
  int          protoErr = 0;
  logic        pend = 1'b0;
  logic [31:0] pendAddr;
  logic        pendWe;
  word_t       pendData;

  always @(posedge clk) begin
    pend     <= mem_req && !mem_ready;
    pendAddr <= mem_addr;
    pendWe   <= mem_we;
    pendData <= mem_wdata;
  end

  always @(negedge clk) begin
    if (rst_b && cache_write_en && mem_req && mem_we) protoErr <= protoErr + 1;
    else if (rst_b && pend && (!mem_req || mem_addr !== pendAddr || mem_we !== pendWe ||
                               mem_wdata !== pendData)) protoErr <= protoErr + 1;
  end

  // Drives one access from posedge+1 and holds it until stall drops; returns at posedge+1.
  task automatic doAccess(input logic we, input logic [31:0] addr, input word_t wd,
                          output int lat, output word_t rd, output logic ok);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; ok = 1'b0; rd = '0;
    while (!ok && lat < 50) begin
      #1;
      lat++;
      if (!cpu_stall) begin
        ok = 1'b1;
        rd = cpu_rdata;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1;
    #1;
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b want 0", cpu_stall); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
    vectors++; if (cache_write_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cache_we got %b want 0", cache_write_en); end
    vectors++; if (cache_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cache_addr got %h want 0", cache_addr); end
    vectors++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss_clean();
    int lat; word_t rd; logic ok; int base;
    base = logCount; memWait = 3;
    doAccess(1'b0, 32'h0000_1234, '0, lat, rd, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL miss1_timeout got %b want 1", ok); end
    vectors++; if (lat != 6) begin miscompares++; $display("[TB] FAIL miss1_latency got %0d want 6", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL miss1_rdata got %h want deadbeef", rd); end
    vectors++; if (logCount - base != 1) begin miscompares++; $display("[TB] FAIL miss1_mem_txns got %0d want 1", logCount - base); end
    vectors++; if (logAddr[base] !== 32'h0000_1234 || logWe[base] !== 1'b0) begin miscompares++; $display("[TB] FAIL miss1_mem_read got addr %h we %b want 00001234/0", logAddr[base], logWe[base]); end
    vectors++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin miscompares++; $display("[TB] FAIL miss1_counters got %0d/%0d want 0/1 (hit/miss)", hit_count, miss_count); end
  endtask

  task automatic test_load_hit();
    int lat; word_t rd; logic ok; int base;
    base = memReqCycles;
    doAccess(1'b0, 32'h0000_1234, '0, lat, rd, ok);
    vectors++; if (ok !== 1'b1 || lat != 2) begin miscompares++; $display("[TB] FAIL hit_latency got %0d want 2", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL hit_rdata got %h want deadbeef", rd); end
    vectors++; if (memReqCycles != base) begin miscompares++; $display("[TB] FAIL hit_no_mem got %0d req cycles want 0", memReqCycles - base); end
    vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin miscompares++; $display("[TB] FAIL hit_counters got %0d/%0d want 1/1", hit_count, miss_count); end
  endtask

  task automatic test_store_hit();
    int lat; word_t rd; logic ok; int base; int wrBase;
    base = memReqCycles; wrBase = cacheWrCount;
    doAccess(1'b1, 32'h0000_1234, 32'h11223344, lat, rd, ok);
    vectors++; if (ok !== 1'b1 || lat != 2) begin miscompares++; $display("[TB] FAIL store_latency got %0d want 2", lat); end
    vectors++; if (cacheWrCount - wrBase != 1) begin miscompares++; $display("[TB] FAIL store_cache_writes got %0d want 1", cacheWrCount - wrBase); end
    vectors++; if (lastCacheWdata !== 32'h11223344 || lastCacheDirty !== 1'b1) begin miscompares++; $display("[TB] FAIL store_line got %h dirty %b want 11223344/1", lastCacheWdata, lastCacheDirty); end
    vectors++; if (memReqCycles != base) begin miscompares++; $display("[TB] FAIL store_no_mem got %0d req cycles want 0", memReqCycles - base); end
    vectors++; if (hit_count !== 32'd2) begin miscompares++; $display("[TB] FAIL store_hit_count got %0d want 2", hit_count); end
  endtask

  task automatic test_dirty_eviction();
    int lat; word_t rd; logic ok; int base;
    base = logCount; memWait = 2;
    doAccess(1'b0, 32'h0000_5234, '0, lat, rd, ok);
    vectors++; if (ok !== 1'b1 || lat != 7) begin miscompares++; $display("[TB] FAIL evict_latency got %0d want 7", lat); end
    vectors++; if (logCount - base != 2) begin miscompares++; $display("[TB] FAIL evict_mem_txns got %0d want 2", logCount - base); end
    vectors++; if (logWe[base] !== 1'b1 || logAddr[base] !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL evict_wb_addr got %h we %b want 00001234/1", logAddr[base], logWe[base]); end
    vectors++; if (logData[base] !== 32'h11223344) begin miscompares++; $display("[TB] FAIL evict_wb_data got %h want 11223344", logData[base]); end
    vectors++; if (logWe[base+1] !== 1'b0 || logAddr[base+1] !== 32'h0000_5234) begin miscompares++; $display("[TB] FAIL evict_refill_addr got %h we %b want 00005234/0", logAddr[base+1], logWe[base+1]); end
    vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL evict_rdata got %h want cafef00d", rd); end
    vectors++; if (lastCacheDirty !== 1'b0 || lastCacheWdata !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL evict_refill_line got %h dirty %b want cafef00d/0", lastCacheWdata, lastCacheDirty); end
    vectors++; if (miss_count !== 32'd2 || hit_count !== 32'd2) begin miscompares++; $display("[TB] FAIL evict_counters got %0d/%0d want 2/2", hit_count, miss_count); end
  endtask

  task automatic test_zero_wait();
    int lat; word_t rd; logic ok; int base; int reqBase;
    base = logCount; reqBase = memReqCycles; memWait = 1;
    doAccess(1'b0, 32'h0000_2000, '0, lat, rd, ok);
    vectors++; if (ok !== 1'b1 || lat != 4) begin miscompares++; $display("[TB] FAIL zw_latency got %0d want 4", lat); end
    vectors++; if (memReqCycles - reqBase != 1) begin miscompares++; $display("[TB] FAIL zw_alloc_cycles got %0d want 1", memReqCycles - reqBase); end
    vectors++; if (logCount - base != 1 || logWe[base] !== 1'b0 || logAddr[base] !== 32'h0000_2000) begin miscompares++; $display("[TB] FAIL zw_mem_read got %0d txns addr %h want 1 read of 00002000", logCount - base, logAddr[base]); end
    vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("[TB] FAIL zw_rdata got %h want 0badf00d", rd); end
    vectors++; if (miss_count !== 32'd3) begin miscompares++; $display("[TB] FAIL zw_miss_count got %0d want 3", miss_count); end
  endtask

  task automatic test_reset_in_allocate();
    int lat; word_t rd; logic ok;
    memWait = 10;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000; cpu_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_3000) begin miscompares++; $display("[TB] FAIL rstalloc_pre got req %b addr %h want 1/00003000", mem_req, mem_addr); end
    rst_b = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rstalloc_mem_req got %b want 0", mem_req); end
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rstalloc_stall got %b want 0", cpu_stall); end
    vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin miscompares++; $display("[TB] FAIL rstalloc_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    memWait = 1;
    doAccess(1'b0, 32'h0000_3000, '0, lat, rd, ok);
    vectors++; if (ok !== 1'b1 || lat != 4) begin miscompares++; $display("[TB] FAIL rstalloc_next_latency got %0d want 4", lat); end
    vectors++; if (rd !== 32'h600DCAFE) begin miscompares++; $display("[TB] FAIL rstalloc_next_rdata got %h want 600dcafe", rd); end
    vectors++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin miscompares++; $display("[TB] FAIL rstalloc_next_counters got %0d/%0d want 0/1", hit_count, miss_count); end
  endtask

  task automatic test_protocol();
    vectors++; if (protoErr != 0) begin miscompares++; $display("[TB] FAIL mem_protocol got %0d violations want 0", protoErr); end
  endtask

  initial begin
    rst_b = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    memArr[14'h048D] = 32'hDEADBEEF;
    memArr[14'h148D] = 32'hCAFEF00D;
    memArr[14'h0800] = 32'h0BADF00D;
    memArr[14'h0C00] = 32'h600DCAFE;
    #2;
    test_reset();
    test_load_miss_clean();
    test_load_hit();
    test_store_hit();
    test_dirty_eviction();
    test_zero_wait();
    test_reset_in_allocate();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Miss-handling FSM between the MIPS memory stage, the direct-mapped data cache, and main memory.
- Accepts one CPU word access at a time and probes the cache. Stalls the CPU on a miss.
- On a miss: writes back a dirty victim, refills the line from memory (write-allocate, write-back), then completes the access.
- Keeps saturating hit and miss counters for performance reporting.

Parameters:
- INDEX_W, 12, cache index width; number of lines = 2**INDEX_W.
- TAG_W, 2, tag width (16 - INDEX_W - 2); address bits 31:16 are treated as zero by the memory map.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-low
- cpu_req  in  1  access request; CPU holds request and inputs stable while cpu_stall=1
- cpu_we  in  1  1=store word, 0=load word
- cpu_addr  in  32  byte address; bits 1:0 ignored
- cpu_wdata  in  [7:0]x[0:3]  store data
- cpu_rdata  out  [7:0]x[0:3]  load data, valid when the access completes
- cpu_stall  out  1  CPU must hold
- cache_addr  out  32  address presented to the cache (latched cpu_addr)
- cache_hit  in  1  tag match and valid for cache_addr
- cache_dirty  in  1  dirty bit of the indexed line
- cache_victim_tag  in  TAG_W  tag stored in the indexed line
- cache_rdata  in  [7:0]x[0:3]  indexed line data
- cache_wdata  out  [7:0]x[0:3]  line write data
- cache_write_en  out  1  write line, set valid and tag from cache_addr
- cache_mark_dirty  out  1  dirty value written with cache_write_en
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  [7:0]x[0:3]  write data
- mem_rdata  in  [7:0]x[0:3]  read data, valid with mem_ready
- mem_ready  in  1  request completes on this clock edge
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- Reset (async, rst_b=0):
  - Forces IDLE; clears latched request and the refilled flag.
  - All outputs 0; counters 0.
  - A memory transaction in flight is abandoned by dropping mem_req; memory must tolerate this.
- IDLE:
  - cpu_stall = cpu_req.
  - On cpu_req=1: latch addr, we and wdata; clear refilled; go to COMPARE.
- COMPARE, cache_hit=1:
  - cpu_stall=0 and cpu_rdata=cache_rdata in this cycle; go to IDLE.
  - Store: cache_write_en=1, cache_wdata=latched wdata, cache_mark_dirty=1.
  - hit_count increments only if refilled=0.
  - Hit latency: 2 cycles from request to completion.
- COMPARE, cache_hit=0:
  - cpu_stall=1; miss_count increments.
  - Latch cache_rdata and cache_victim_tag.
  - Go to WRITEBACK if cache_dirty=1, else ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_wdata=latched victim data.
  - mem_addr = {16'b0, victim_tag, index, 2'b00}.
  - On mem_ready: go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr = {latched addr[31:2], 2'b00}.
  - On mem_ready: cache_write_en=1, cache_wdata=mem_rdata, cache_mark_dirty=0; set refilled; go to COMPARE, which then hits.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay constant until mem_ready=1 is sampled.
  - mem_ready is ignored while mem_req=0.
  - mem_ready may be high in the first cycle of the state (zero-wait memory).
- Miss latency: 2 + (writeback wait) + (allocate wait) + 1 cycles.
- cpu_req dropping mid-miss is a protocol violation. The controller finishes the refill from its latched copy and completes in COMPARE anyway.
- Counters stop at 32'hFFFF_FFFF.
- cache_write_en and mem_req are never both asserted with mem_we=1 in the same cycle.

Decomposition:
- Package mips_cache_pkg holds:
  - word_t (four bytes)
  - cache_state_e enum
  - INDEX_W / TAG_W defaults
  - function to build the memory address from tag and index
- One sub-module: sat_counter (32-bit, inc, async reset), instantiated twice.

Test Plan:
- Load miss on a clean line, addr 0x0000_1234, memory ready after 3 wait cycles, returns 0xDEADBEEF. Required: mem read to 0x0000_1234; cpu_rdata=0xDEADBEEF when stall drops, 6 cycles after request; miss_count=1, hit_count=0.
- Load of the same address again. Required: completes in 2 cycles with 0xDEADBEEF; no mem_req; hit_count=1.
- Store hit 0x0000_1234 with 0x11223344. Required: cache_write_en with mark_dirty=1; no memory traffic.
- Load 0x0000_5234 (same index, different tag) with the line dirty. Required: mem write of 0x11223344 to 0x0000_1234; then mem read of 0x0000_5234; then refill; miss_count=2.
- Zero-wait memory (mem_ready tied 1) on a clean miss. Required: WRITEBACK skipped; ALLOCATE lasts 1 cycle; total latency 4 cycles.
- rst_b pulsed low during ALLOCATE. Required: mem_req=0 and cpu_stall=0 immediately; counters 0; the next request starts from IDLE normally.
